// File: rtl/improve_edge_pkg.sv
// Shared constants for the improve_edge pipeline (detector, binarize, writer).
//   DEF_ROWS / DEF_COLS       : default frame geometry
//   DEF_BORDER                : rows/cols lost to 3x3 window warm-up
//   DEF_THR_HI / DEF_THR_LO   : thresholds loaded at reset
//   cnt_w(rows, cols)         : width that holds a full-frame pixel count
package improve_edge_pkg;

    localparam int         DEF_ROWS   = 242;
    localparam int         DEF_COLS   = 247;
    localparam int         DEF_BORDER = 2;
    localparam logic [7:0] DEF_THR_HI = 8'd96;
    localparam logic [7:0] DEF_THR_LO = 8'd48;

    function automatic int cnt_w(input int rows, input int cols);
        return $clog2(rows * cols + 1);
    endfunction

endpackage

// File: rtl/edge_binarize_stage_raster_counter.sv
// raster_counter: column/row position of the pixel stream.
//   clk, rst        : clock, async active-high reset
//   valid_in        : beat strobe; position advances only on beats
//   sof_in          : start-of-frame resync, qualified by valid_in
//   col, row        : position of the current beat (already forced to 0,0 on sof)
//   first, eol, eof : current beat is frame-first / last column / last pixel
module raster_counter #(
    parameter int ROWS  = 242,
    parameter int COLS  = 247,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             sof_in,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             first,
    output logic             eol,
    output logic             eof
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             last_row;

    always_comb begin
        // sof overrides the stored position for this very beat
        col      = (valid_in && sof_in) ? '0 : col_q;
        row      = (valid_in && sof_in) ? '0 : row_q;
        last_row = (row == ROW_W'(ROWS - 1));
        first    = valid_in && (col == '0) && (row == '0);
        eol      = valid_in && (col == COL_W'(COLS - 1));
        eof      = eol && last_row;

        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (eol) begin
                col_d = '0;
                row_d = last_row ? '0 : row + ROW_W'(1);
            end else begin
                col_d = col + COL_W'(1);
                row_d = row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/edge_binarize_stage.sv
// edge_binarize_stage: border suppression, thresholding and per-frame edge
// count for the Prewitt edge-strength stream. One register stage of latency.
//   clk, rst              : clock, async active-high reset
//   pixel_in, valid_in    : edge strength and its beat strobe (gaps allowed)
//   sof_in                : start-of-frame resync (with valid_in)
//   thr_hi, thr_lo        : thresholds, captured on each frame's first beat
//   bin_out, valid_out    : binary edge pixel and its strobe
//   eol_out, eof_out      : last column of row / last pixel of frame
//   edge_count            : edge total of the last complete frame
//   count_valid           : one-cycle strobe when edge_count updates
// Build option: define HYSTERESIS_EN for horizontal hysteresis using thr_lo.
module edge_binarize_stage
    import improve_edge_pkg::*;
#(
    parameter int         ROWS   = DEF_ROWS,
    parameter int         COLS   = DEF_COLS,
    parameter int         BORDER = DEF_BORDER,
    parameter logic [7:0] DEF_HI = DEF_THR_HI,
    parameter logic [7:0] DEF_LO = DEF_THR_LO,
    parameter int         CNT_W  = cnt_w(ROWS, COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       pixel_in,
    input  logic             valid_in,
    input  logic             sof_in,
    input  logic [7:0]       thr_hi,
    input  logic [7:0]       thr_lo,
    output logic             bin_out,
    output logic             valid_out,
    output logic             eol_out,
    output logic             eof_out,
    output logic [CNT_W-1:0] edge_count,
    output logic             count_valid
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             first, eol, eof;

    raster_counter #(
        .ROWS (ROWS),
        .COLS (COLS),
        .COL_W(COL_W),
        .ROW_W(ROW_W)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .valid_in(valid_in),
        .sof_in  (sof_in),
        .col     (col),
        .row     (row),
        .first   (first),
        .eol     (eol),
        .eof     (eof)
    );

    logic [7:0]       hi_q, hi_d;
    logic [CNT_W-1:0] acc_q, acc_d, acc_base, acc_sum;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;
    logic             bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             eol_q, eol_d;
    logic             eof_q, eof_d;
    logic             count_valid_q, count_valid_d;
    logic             border, bin;

`ifdef HYSTERESIS_EN
    logic [7:0] lo_q, lo_d;
    logic       prev_q, prev_d, prev_eff;
`else
    logic       unused_lo;
    assign unused_lo = ^{thr_lo, DEF_LO};
`endif

    always_comb begin
        // live port value applies to the frame-first beat itself
        hi_d   = first ? thr_hi : hi_q;
        border = (row < ROW_W'(BORDER)) || (col < COL_W'(BORDER));
`ifdef HYSTERESIS_EN
        lo_d     = first ? thr_lo : lo_q;
        prev_eff = (col == '0) ? 1'b0 : prev_q;
        bin      = !border && ((pixel_in >= hi_d) || ((pixel_in >= lo_d) && prev_eff));
        prev_d   = valid_in ? bin : prev_q;
`else
        bin      = !border && (pixel_in >= hi_d);
`endif

        // a frame-first beat discards whatever a truncated frame left behind
        acc_base = first ? '0 : acc_q;
        acc_sum  = acc_base + CNT_W'(bin);

        acc_d        = acc_q;
        edge_count_d = edge_count_q;
        if (valid_in) begin
            if (eof) begin
                edge_count_d = acc_sum;
                acc_d        = '0;
            end else begin
                acc_d = acc_sum;
            end
        end

        bin_d         = valid_in && bin;
        valid_d       = valid_in;
        eol_d         = eol;
        eof_d         = eof;
        count_valid_d = eof;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q          <= DEF_HI;
            acc_q         <= '0;
            edge_count_q  <= '0;
            bin_q         <= 1'b0;
            valid_q       <= 1'b0;
            eol_q         <= 1'b0;
            eof_q         <= 1'b0;
            count_valid_q <= 1'b0;
        end else begin
            hi_q          <= hi_d;
            acc_q         <= acc_d;
            edge_count_q  <= edge_count_d;
            bin_q         <= bin_d;
            valid_q       <= valid_d;
            eol_q         <= eol_d;
            eof_q         <= eof_d;
            count_valid_q <= count_valid_d;
        end
    end

`ifdef HYSTERESIS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q   <= DEF_LO;
            prev_q <= 1'b0;
        end else begin
            lo_q   <= lo_d;
            prev_q <= prev_d;
        end
    end
`endif

    assign bin_out     = bin_q;
    assign valid_out   = valid_q;
    assign eol_out     = eol_q;
    assign eof_out     = eof_q;
    assign edge_count  = edge_count_q;
    assign count_valid = count_valid_q;

endmodule
